// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles every signal between the data memory arbiter, its two requesters
// (A = pipeline MEM stage, B = loader/debug port) and the data memory.
//
// Requester side : reqA/reqB, weA/weB, addrA/addrB (8b word address),
//                  wdataA/wdataB (32b) in; gntA/gntB, doneA/doneB pulses and
//                  rdataA/rdataB (last read result) out.
// Memory side    : memAddress (8b), memWriteData (32b), memEnRead,
//                  memEnWrite out; memReadData (32b) in, valid after the
//                  rising edge at which memEnRead was high.
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the memory model)
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if;
  logic        reqA;
  logic        reqB;
  logic        weA;
  logic        weB;
  logic [7:0]  addrA;
  logic [7:0]  addrB;
  logic [31:0] wdataA;
  logic [31:0] wdataB;
  logic        gntA;
  logic        gntB;
  logic        doneA;
  logic        doneB;
  logic [31:0] rdataA;
  logic [31:0] rdataB;
  logic [7:0]  memAddress;
  logic [31:0] memWriteData;
  logic        memEnRead;
  logic        memEnWrite;
  logic [31:0] memReadData;

  modport slave (
    input  reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, memReadData,
    output gntA, gntB, doneA, doneB, rdataA, rdataB,
           memAddress, memWriteData, memEnRead, memEnWrite
  );

  modport master (
    output reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, memReadData,
    input  gntA, gntB, doneA, doneB, rdataA, rdataB,
           memAddress, memWriteData, memEnRead, memEnWrite
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port data memory between two requesters with round-robin
// arbitration. One transaction is in flight at a time:
//   IDLE  -> sample requests, latch the winner, pulse its grant
//   ISSUE -> memory enable asserted for exactly this cycle
//   RESP  -> (reads only) capture memReadData into the owner's rdata
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high; aborts any transaction in flight
//   bus   - data_mem_arbiter_if.slave (requester handshakes + memory port)
// ---------------------------------------------------------------------------
module data_mem_arbiter (
  input logic               clock,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        lastOwner_q, lastOwner_d;
  logic        we_q, we_d;
  logic [7:0]  memAddress_q, memAddress_d;
  logic [31:0] memWriteData_q, memWriteData_d;
  logic        memEnRead_q, memEnRead_d;
  logic        memEnWrite_q, memEnWrite_d;
  logic        gntA_q, gntA_d;
  logic        gntB_q, gntB_d;
  logic        doneA_q, doneA_d;
  logic        doneB_q, doneB_d;
  logic [31:0] rdataA_q, rdataA_d;
  logic [31:0] rdataB_q, rdataB_d;
  logic        pickB;

  // B wins when it is the only requester, or on a tie when A was served last.
  assign pickB = bus.reqB & (~bus.reqA | (lastOwner_q == OWNER_A));

  // Next-state and next-output logic. The latched address/data are held in
  // the memory address/data output registers themselves, so they stay put
  // for the whole transaction regardless of what the requester does after
  // its grant. Grant, done and the memory enables are single-cycle pulses
  // and therefore default to 0 every cycle.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    lastOwner_d    = lastOwner_q;
    we_d           = we_q;
    memAddress_d   = memAddress_q;
    memWriteData_d = memWriteData_q;
    memEnRead_d    = 1'b0;
    memEnWrite_d   = 1'b0;
    gntA_d         = 1'b0;
    gntB_d         = 1'b0;
    doneA_d        = 1'b0;
    doneB_d        = 1'b0;
    rdataA_d       = rdataA_q;
    rdataB_d       = rdataB_q;

    unique case (state_q)
      IDLE: begin
        if (bus.reqA || bus.reqB) begin
          owner_d        = pickB;
          lastOwner_d    = pickB;
          we_d           = pickB ? bus.weB    : bus.weA;
          memAddress_d   = pickB ? bus.addrB  : bus.addrA;
          memWriteData_d = pickB ? bus.wdataB : bus.wdataA;
          memEnWrite_d   = pickB ? bus.weB    : bus.weA;
          memEnRead_d    = pickB ? ~bus.weB   : ~bus.weA;
          gntA_d         = ~pickB;
          gntB_d         = pickB;
          state_d        = ISSUE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          doneA_d = (owner_q == OWNER_A);
          doneB_d = (owner_q == OWNER_B);
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (owner_q == OWNER_A) begin
          rdataA_d = bus.memReadData;
        end else begin
          rdataB_d = bus.memReadData;
        end
        doneA_d = (owner_q == OWNER_A);
        doneB_d = (owner_q == OWNER_B);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything immediately, which
  // drops the memory enables mid-transaction and discards any pending done.
  // lastOwner resets to B so that A wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWNER_A;
      lastOwner_q    <= OWNER_B;
      we_q           <= 1'b0;
      memAddress_q   <= 8'h00;
      memWriteData_q <= 32'h0000_0000;
      memEnRead_q    <= 1'b0;
      memEnWrite_q   <= 1'b0;
      gntA_q         <= 1'b0;
      gntB_q         <= 1'b0;
      doneA_q        <= 1'b0;
      doneB_q        <= 1'b0;
      rdataA_q       <= 32'h0000_0000;
      rdataB_q       <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      lastOwner_q    <= lastOwner_d;
      we_q           <= we_d;
      memAddress_q   <= memAddress_d;
      memWriteData_q <= memWriteData_d;
      memEnRead_q    <= memEnRead_d;
      memEnWrite_q   <= memEnWrite_d;
      gntA_q         <= gntA_d;
      gntB_q         <= gntB_d;
      doneA_q        <= doneA_d;
      doneB_q        <= doneB_d;
      rdataA_q       <= rdataA_d;
      rdataB_q       <= rdataB_d;
    end
  end

  assign bus.gntA         = gntA_q;
  assign bus.gntB         = gntB_q;
  assign bus.doneA        = doneA_q;
  assign bus.doneB        = doneB_q;
  assign bus.rdataA       = rdataA_q;
  assign bus.rdataB       = rdataB_q;
  assign bus.memAddress   = memAddress_q;
  assign bus.memWriteData = memWriteData_q;
  assign bus.memEnRead    = memEnRead_q;
  assign bus.memEnWrite   = memEnWrite_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Drives data_mem_arbiter through directed scenarios and randomized traffic.
// A synchronous memory model answers the arbiter's memory port; a
// transaction-level reference (round-robin winner, shadow memory, expected
// rdata per port, fixed latencies) predicts what each port should see.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] memArr [256];
  bit          memInit;

  logic [31:0] refMem [256];
  logic        refLast;
  logic [31:0] refRdA;
  logic [31:0] refRdB;

  data_mem_arbiter_if ifc();

  data_mem_arbiter dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clock = ~clock;

  // Deterministic power-up content so the reference can reproduce it.
  function automatic logic [31:0] seedWord(input int i);
    logic [7:0] a;
    a = i[7:0];
    return {a, ~a, a ^ 8'hA5, 8'h3C};
  endfunction

  // Synchronous memory: writes land at the edge, read data appears after it.
  always @(posedge clock) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) memArr[i] <= seedWord(i);
      memInit <= 1'b1;
    end else begin
      if (ifc.memEnWrite) memArr[ifc.memAddress] <= ifc.memWriteData;
      if (ifc.memEnRead)  ifc.memReadData <= memArr[ifc.memAddress];
    end
  end

  task automatic applyIdle;
    ifc.reqA   = 1'b0;
    ifc.reqB   = 1'b0;
    ifc.weA    = 1'b0;
    ifc.weB    = 1'b0;
    ifc.addrA  = 8'h00;
    ifc.addrB  = 8'h00;
    ifc.wdataA = 32'h0;
    ifc.wdataB = 32'h0;
  endtask

  task automatic applyResetPulse;
    @(negedge clock);
    reset = 1'b1;
    applyIdle();
    @(negedge clock);
    reset = 1'b0;
    refLast = 1'b1;
    refRdA  = 32'h0;
    refRdB  = 32'h0;
  endtask

  // Presents one request round (one or both ports), drops requests when a
  // grant appears (optionally scrambling the fields), and reports what was
  // observed. Cycle numbers count negedges after the request was presented.
  task automatic runTxn(
    input  bit rA, input bit rB, input bit wA, input bit wB,
    input  logic [7:0] aA, input logic [7:0] aB,
    input  logic [31:0] dA, input logic [31:0] dB, input bit scramble,
    output bit gotA, output bit gotB, output int gntK, output int doneK,
    output int rdCyc, output int wrCyc, output bit addrOk, output bit bad,
    output int nDoneA, output int nDoneB, output logic [31:0] rdAtDone);
    logic [7:0] expAddr;
    gotA = 0; gotB = 0; gntK = -1; doneK = -1; rdCyc = 0; wrCyc = 0;
    addrOk = 1; bad = 0; nDoneA = 0; nDoneB = 0; rdAtDone = 32'hx;
    expAddr = 8'h00;
    @(negedge clock);
    ifc.reqA = rA; ifc.weA = wA; ifc.addrA = aA; ifc.wdataA = dA;
    ifc.reqB = rB; ifc.weB = wB; ifc.addrB = aB; ifc.wdataB = dB;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if ((ifc.gntA && ifc.gntB) || (ifc.doneA && ifc.doneB) ||
          (ifc.memEnRead && ifc.memEnWrite)) bad = 1;
      if (ifc.memEnRead)  rdCyc++;
      if (ifc.memEnWrite) wrCyc++;
      if (ifc.doneA) nDoneA++;
      if (ifc.doneB) nDoneB++;
      if (ifc.gntA || ifc.gntB) begin
        if (gntK < 0) begin
          gntK = k; gotA = ifc.gntA; gotB = ifc.gntB;
          expAddr = ifc.gntB ? aB : aA;
        end
        ifc.reqA = 1'b0;
        ifc.reqB = 1'b0;
        if (scramble) begin
          ifc.addrA = ~aA; ifc.addrB = ~aB;
          ifc.wdataA = ~dA; ifc.wdataB = ~dB;
          ifc.weA = ~wA; ifc.weB = ~wB;
        end
      end
      if (gntK > 0 && doneK < 0 && !(ifc.doneA || ifc.doneB) &&
          ifc.memAddress !== expAddr) addrOk = 0;
      if ((ifc.doneA || ifc.doneB) && doneK < 0) begin
        doneK = k;
        rdAtDone = ifc.doneA ? ifc.rdataA : ifc.rdataB;
      end
      if (doneK > 0 && k >= doneK + 2) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyIdle();
    repeat (2) @(negedge clock);
    checks++;
    if (ifc.gntA !== 1'b0 || ifc.gntB !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_gnt: got %b%b expected 00", ifc.gntA, ifc.gntB);
    end
    checks++;
    if (ifc.doneA !== 1'b0 || ifc.doneB !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done: got %b%b expected 00", ifc.doneA, ifc.doneB);
    end
    checks++;
    if (ifc.memEnRead !== 1'b0 || ifc.memEnWrite !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_en: got rd=%b wr=%b expected 0 0", ifc.memEnRead, ifc.memEnWrite);
    end
    checks++;
    if (ifc.memAddress !== 8'h00 || ifc.memWriteData !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_membus: got addr=%h data=%h expected 0 0", ifc.memAddress, ifc.memWriteData);
    end
    checks++;
    if (ifc.rdataA !== 32'h0 || ifc.rdataB !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_rdata: got A=%h B=%h expected 0 0", ifc.rdataA, ifc.rdataB);
    end
    reset = 1'b0;
    refLast = 1'b1;
    refRdA  = 32'h0;
    refRdB  = 32'h0;
    begin
      bit seen;
      seen = 0;
      repeat (4) begin
        @(negedge clock);
        if (ifc.gntA || ifc.gntB || ifc.memEnRead || ifc.memEnWrite) seen = 1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++; $display("[TB] FAIL idle_no_request: got activity=%b expected 0", seen);
      end
    end
  endtask

  task automatic test_write_a;
    bit gA, gB, aok, bd; int gk, dk, rc, wc, nA, nB; logic [31:0] rdd;
    runTxn(1, 0, 1, 0, 8'h00, 8'h00, 32'hF0FFFFFF, 32'h0, 0,
           gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
    checks++;
    if (gA !== 1'b1 || gB !== 1'b0) begin
      errors++; $display("[TB] FAIL writeA_grant: got A=%b B=%b expected A=1 B=0", gA, gB);
    end
    checks++;
    if (gk !== 1 || dk !== 2) begin
      errors++; $display("[TB] FAIL writeA_latency: got gnt@%0d done@%0d expected 1 2", gk, dk);
    end
    checks++;
    if (wc !== 1 || rc !== 0) begin
      errors++; $display("[TB] FAIL writeA_enables: got wr=%0d rd=%0d cycles expected 1 0", wc, rc);
    end
    checks++;
    if (aok !== 1'b1 || bd !== 1'b0 || nA !== 1 || nB !== 0) begin
      errors++; $display("[TB] FAIL writeA_bus: got addrOk=%b overlap=%b doneA=%0d doneB=%0d expected 1 0 1 0", aok, bd, nA, nB);
    end
    refMem[0] = 32'hF0FFFFFF;
    refLast = 1'b0;
  endtask

  task automatic test_read_a;
    bit gA, gB, aok, bd; int gk, dk, rc, wc, nA, nB; logic [31:0] rdd;
    runTxn(1, 0, 0, 0, 8'h00, 8'h00, 32'h0, 32'h0, 0,
           gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
    checks++;
    if (gA !== 1'b1 || gk !== 1 || dk !== 3) begin
      errors++; $display("[TB] FAIL readA_latency: got gntA=%b gnt@%0d done@%0d expected 1 1 3", gA, gk, dk);
    end
    checks++;
    if (rc !== 1 || wc !== 0) begin
      errors++; $display("[TB] FAIL readA_enables: got rd=%0d wr=%0d cycles expected 1 0", rc, wc);
    end
    checks++;
    if (rdd !== refMem[0]) begin
      errors++; $display("[TB] FAIL readA_data: got %h expected %h", rdd, refMem[0]);
    end
    checks++;
    if (ifc.rdataB !== refRdB) begin
      errors++; $display("[TB] FAIL readA_otherB: got %h expected %h", ifc.rdataB, refRdB);
    end
    refRdA  = refMem[0];
    refLast = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic order [4];
    logic expOwner;
    logic last;
    int grants, dones;
    bit bd;
    applyResetPulse();
    grants = 0; dones = 0; bd = 0;
    ifc.reqA = 1'b1; ifc.weA = 1'b1; ifc.addrA = 8'h40; ifc.wdataA = $urandom;
    ifc.reqB = 1'b1; ifc.weB = 1'b1; ifc.addrB = 8'h50; ifc.wdataB = $urandom;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if ((ifc.gntA && ifc.gntB) || (ifc.doneA && ifc.doneB) ||
          (ifc.memEnRead && ifc.memEnWrite)) bd = 1;
      if (ifc.doneA || ifc.doneB) dones++;
      if ((ifc.gntA || ifc.gntB) && grants < 4) begin
        order[grants] = ifc.gntB;
        if (ifc.gntB) refMem[ifc.addrB] = ifc.wdataB;
        else          refMem[ifc.addrA] = ifc.wdataA;
        grants++;
        if (grants == 4) begin
          ifc.reqA = 1'b0;
          ifc.reqB = 1'b0;
        end else if (ifc.gntB) begin
          ifc.addrB = ifc.addrB + 8'h01; ifc.wdataB = $urandom;
        end else begin
          ifc.addrA = ifc.addrA + 8'h01; ifc.wdataA = $urandom;
        end
      end
    end
    checks++;
    if (grants !== 4) begin
      errors++; $display("[TB] FAIL b2b_grant_count: got %0d expected 4", grants);
    end
    last = refLast;
    for (int i = 0; i < 4; i++) begin
      expOwner = ~last;
      last = expOwner;
      if (i < grants) begin
        checks++;
        if (order[i] !== expOwner) begin
          errors++; $display("[TB] FAIL b2b_order[%0d]: got %s expected %s", i,
                             order[i] ? "B" : "A", expOwner ? "B" : "A");
        end
      end
    end
    refLast = last;
    checks++;
    if (dones !== 4 || bd !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_done: got dones=%0d overlap=%b expected 4 0", dones, bd);
    end
  endtask

  task automatic test_read_b;
    bit gA, gB, aok, bd; int gk, dk, rc, wc, nA, nB; logic [31:0] rdd;
    runTxn(0, 1, 0, 0, 8'h00, 8'h10, 32'h0, 32'hFFFFFFFF, 0,
           gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
    checks++;
    if (gB !== 1'b1 || gA !== 1'b0 || gk !== 1 || dk !== 3) begin
      errors++; $display("[TB] FAIL readB_latency: got gntA=%b gntB=%b gnt@%0d done@%0d expected 0 1 1 3", gA, gB, gk, dk);
    end
    checks++;
    if (wc !== 0 || rc !== 1 || nA !== 0) begin
      errors++; $display("[TB] FAIL readB_enables: got wr=%0d rd=%0d doneA=%0d expected 0 1 0", wc, rc, nA);
    end
    checks++;
    if (rdd !== refMem[8'h10]) begin
      errors++; $display("[TB] FAIL readB_data: got %h expected %h", rdd, refMem[8'h10]);
    end
    checks++;
    if (ifc.rdataA !== refRdA) begin
      errors++; $display("[TB] FAIL readB_otherA: got %h expected %h", ifc.rdataA, refRdA);
    end
    refRdB  = refMem[8'h10];
    refLast = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit gA, gB, aok, bd; int gk, dk, rc, wc, nA, nB; logic [31:0] rdd;
    logic [31:0] wd;
    bit granted;
    int strayDone;
    granted = 0; strayDone = 0;
    @(negedge clock);
    ifc.reqA = 1'b1; ifc.weA = 1'b0; ifc.addrA = 8'h00;
    for (int k = 0; k < 6 && !granted; k++) begin
      @(negedge clock);
      if (ifc.gntA) granted = 1;
    end
    checks++;
    if (granted !== 1'b1 || ifc.memEnRead !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_issue: got granted=%b memEnRead=%b expected 1 1", granted, ifc.memEnRead);
    end
    ifc.reqA = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.memEnRead !== 1'b0 || ifc.memEnWrite !== 1'b0 || ifc.gntA !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_async: got rd=%b wr=%b gntA=%b expected 0 0 0", ifc.memEnRead, ifc.memEnWrite, ifc.gntA);
    end
    @(negedge clock);
    reset = 1'b0;
    refLast = 1'b1; refRdA = 32'h0; refRdB = 32'h0;
    repeat (4) begin
      @(negedge clock);
      if (ifc.doneA || ifc.doneB || ifc.gntA || ifc.gntB) strayDone++;
    end
    checks++;
    if (strayDone !== 0 || ifc.rdataA !== 32'h0) begin
      errors++; $display("[TB] FAIL rstmid_abort: got stray=%0d rdataA=%h expected 0 0", strayDone, ifc.rdataA);
    end
    wd = $urandom;
    runTxn(1, 0, 1, 0, 8'h77, 8'h00, wd, 32'h0, 0,
           gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
    checks++;
    if (gA !== 1'b1 || gk !== 1 || dk !== 2 || wc !== 1) begin
      errors++; $display("[TB] FAIL rstmid_next: got gntA=%b gnt@%0d done@%0d wr=%0d expected 1 1 2 1", gA, gk, dk, wc);
    end
    refMem[8'h77] = wd;
    refLast = 1'b0;
  endtask

  task automatic test_addr_change;
    bit gA, gB, aok, bd; int gk, dk, rc, wc, nA, nB; logic [31:0] rdd;
    logic [31:0] wd;
    runTxn(1, 0, 0, 0, 8'h10, 8'h00, 32'h0, 32'h0, 1,
           gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
    checks++;
    if (aok !== 1'b1 || rdd !== refMem[8'h10] || dk !== 3) begin
      errors++; $display("[TB] FAIL addrchg_read: got addrOk=%b data=%h done@%0d expected 1 %h 3", aok, rdd, dk, refMem[8'h10]);
    end
    refRdA = refMem[8'h10];
    wd = $urandom;
    runTxn(1, 0, 1, 0, 8'h33, 8'h00, wd, 32'h0, 1,
           gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
    checks++;
    if (aok !== 1'b1 || wc !== 1 || rc !== 0) begin
      errors++; $display("[TB] FAIL addrchg_write: got addrOk=%b wr=%0d rd=%0d expected 1 1 0", aok, wc, rc);
    end
    refMem[8'h33] = wd;
    runTxn(1, 0, 0, 0, 8'h33, 8'h00, 32'h0, 32'h0, 0,
           gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
    checks++;
    if (rdd !== refMem[8'h33]) begin
      errors++; $display("[TB] FAIL addrchg_readback: got %h expected %h", rdd, refMem[8'h33]);
    end
    refRdA  = refMem[8'h33];
    refLast = 1'b0;
  endtask

  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      bit rA, rB, wA, wB, expB, expWe, gA, gB, aok, bd;
      logic [7:0] aA, aB, expAddr;
      logic [31:0] dA, dB, expData, rdd;
      int gk, dk, rc, wc, nA, nB, expDone;
      rA = 1'($urandom_range(0, 1));
      rB = 1'($urandom_range(0, 1));
      if (!rA && !rB) rA = 1'b1;
      wA = 1'($urandom_range(0, 1));
      wB = 1'($urandom_range(0, 1));
      aA = 8'($urandom_range(0, 31)) | ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h00);
      aB = 8'($urandom_range(0, 31)) | ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h00);
      dA = $urandom;
      dB = $urandom;
      expB    = (rA && rB) ? ~refLast : rB;
      expWe   = expB ? wB : wA;
      expAddr = expB ? aB : aA;
      expData = expB ? dB : dA;
      expDone = expWe ? 2 : 3;
      runTxn(rA, rB, wA, wB, aA, aB, dA, dB, 1'($urandom_range(0, 1)),
             gA, gB, gk, dk, rc, wc, aok, bd, nA, nB, rdd);
      checks++;
      if (gB !== expB || gA !== ~expB) begin
        errors++; $display("[TB] FAIL rand%0d_winner: got A=%b B=%b expected B=%b", it, gA, gB, expB);
      end
      checks++;
      if (gk !== 1 || dk !== expDone) begin
        errors++; $display("[TB] FAIL rand%0d_latency: got gnt@%0d done@%0d expected 1 %0d", it, gk, dk, expDone);
      end
      checks++;
      if (bd !== 1'b0 || aok !== 1'b1 ||
          (expWe ? (wc !== 1 || rc !== 0) : (rc !== 1 || wc !== 0))) begin
        errors++; $display("[TB] FAIL rand%0d_bus: got overlap=%b addrOk=%b rd=%0d wr=%0d we=%b", it, bd, aok, rc, wc, expWe);
      end
      if (expWe) begin
        refMem[expAddr] = expData;
      end else begin
        checks++;
        if (rdd !== refMem[expAddr]) begin
          errors++; $display("[TB] FAIL rand%0d_rdata: got %h expected %h", it, rdd, refMem[expAddr]);
        end
        if (expB) refRdB = refMem[expAddr];
        else      refRdA = refMem[expAddr];
      end
      checks++;
      if (ifc.rdataA !== refRdA || ifc.rdataB !== refRdB) begin
        errors++; $display("[TB] FAIL rand%0d_hold: got A=%h B=%h expected %h %h", it, ifc.rdataA, ifc.rdataB, refRdA, refRdB);
      end
      refLast = expB;
    end
  endtask

  initial begin
    reset = 1'b1;
    applyIdle();
    for (int i = 0; i < 256; i++) refMem[i] = seedWord(i);
    refLast = 1'b1;
    refRdA  = 32'h0;
    refRdB  = 32'h0;
    test_reset();
    test_write_a();
    test_read_a();
    test_back_to_back();
    test_read_b();
    test_reset_mid();
    test_addr_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
